// File: rtl/programmable_sequence_detector_ctrl_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// Optional macro SEQ_DETECT_MASK_EN enables per-position don't-care masking.
package seq_detect_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MASK_MAX = 64;

  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  // Mask with the lowest len bits set; callers size-cast it to their pattern width.
  function automatic logic [MASK_MAX-1:0] len_mask(input int len);
    logic [MASK_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX; i++) m[i] = (i < len);
    return m;
  endfunction

endpackage

// File: rtl/programmable_sequence_detector_ctrl_if.sv
// Config, stream and status bundle of the sequence detector.
// cfg_mask exists only when SEQ_DETECT_MASK_EN is defined.
interface programmable_sequence_detector_ctrl_if
  import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = len_w(MAX_LEN);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_threshold;
`ifdef SEQ_DETECT_MASK_EN
    logic [MAX_LEN-1:0] cfg_mask;
`endif
    logic               start;
    logic               stop;
    logic               a_valid;
    logic               a;
    logic               busy;
    logic               detected;
    logic [CNT_W-1:0]   match_cnt;
    logic               irq;
    logic               irq_clr;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_threshold,
`ifdef SEQ_DETECT_MASK_EN
        output cfg_mask,
`endif
        output start, stop, a_valid, a, irq_clr,
        input  cfg_ready, busy, detected, match_cnt, irq
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_threshold,
`ifdef SEQ_DETECT_MASK_EN
        input  cfg_mask,
`endif
        input  start, stop, a_valid, a, irq_clr,
        output cfg_ready, busy, detected, match_cnt, irq
    );

endinterface

// File: rtl/programmable_sequence_detector_ctrl_seq_shift_matcher.sv
// Bit history, fill level and masked pattern compare; match is combinational
// and valid only on the cycle whose shift completes the pattern.
module seq_shift_matcher
  import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          shift_en,
    input  logic                          clear,
    input  logic                          a,
    input  logic [len_w(MAX_LEN)-1:0]     len,
    input  logic [MAX_LEN-1:0]            pattern,
    input  logic [MAX_LEN-1:0]            mask,
    output logic                          match
);
    localparam int LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] hist, hist_next, lenmask;
    logic [LEN_W-1:0]   fill, fill_next;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        hist_next = {hist[MAX_LEN-2:0], a};
        fill_next = (fill >= len) ? len : fill + 1'b1;
        lenmask   = MAX_LEN'(len_mask(int'(len)));
        match     = shift_en && !clear && (fill_next >= len) &&
                    (((hist_next ^ pattern) & lenmask & ~mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_next;
            fill <= fill_next;
        end
    end

endmodule

// File: rtl/programmable_sequence_detector_ctrl.sv
// Control FSM, config registers, saturating match counter and sticky irq.
// Define SEQ_DETECT_MASK_EN to latch cfg_mask and treat set bits as don't-care.
module programmable_sequence_detector_ctrl
  import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic rst,
    programmable_sequence_detector_ctrl_if.slave bus
);
    localparam int LEN_W = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_e             state, state_next;
    logic [MAX_LEN-1:0] pattern_q, mask_q;
    logic [LEN_W-1:0]   len_q, len_clamped;
    logic [CNT_W-1:0]   thr_q, cnt_q;
    logic               det_q, irq_q;
    logic               cfg_accept, dp_clear, cnt_clear, shift_en, match, irq_set;

    always_comb begin
        state_next = state;
        cfg_accept = 1'b0;
        dp_clear   = 1'b0;
        cnt_clear  = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                cfg_accept = bus.cfg_valid;
                if (bus.start) begin
                    state_next = RUN;
                    dp_clear   = 1'b1;
                    cnt_clear  = 1'b1;
                end
            end
            RUN: begin
                // stop has priority over any bit arriving in the same cycle
                if (bus.stop) begin
                    state_next = IDLE;
                    dp_clear   = 1'b1;
                end else begin
                    shift_en = bus.a_valid;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        len_clamped = bus.cfg_len;
        if (bus.cfg_len == '0)         len_clamped = LEN_ONE;
        else if (bus.cfg_len > LEN_MAX) len_clamped = LEN_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= LEN_ONE;
            pattern_q <= '0;
            thr_q     <= '0;
        end else if (cfg_accept) begin
            len_q     <= len_clamped;
            pattern_q <= bus.cfg_pattern;
            thr_q     <= bus.cfg_threshold;
        end
    end

`ifdef SEQ_DETECT_MASK_EN
    always_ff @(posedge clk) begin
        if (rst)             mask_q <= '0;
        else if (cfg_accept) mask_q <= bus.cfg_mask;
    end
`else
    assign mask_q = '0;
`endif

    seq_shift_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (dp_clear),
        .a        (bus.a),
        .len      (len_q),
        .pattern  (pattern_q),
        .mask     (mask_q),
        .match    (match)
    );

    // Only a real increment can land on the threshold; a saturated count never re-fires.
    assign irq_set = match && !(&cnt_q) && (thr_q != '0) && ((cnt_q + 1'b1) == thr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            det_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            det_q <= match;
            if (cnt_clear)               cnt_q <= '0;
            else if (match && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
            if (irq_set)          irq_q <= 1'b1;
            else if (bus.irq_clr) irq_q <= 1'b0;
        end
    end

    assign bus.cfg_ready = (state == IDLE);
    assign bus.busy      = (state == RUN);
    assign bus.detected  = det_q;
    assign bus.match_cnt = cnt_q;
    assign bus.irq       = irq_q;

endmodule
